// File: rtl/mul_issue_ctrl.sv
// Issue sequencer for the shared multi-cycle multiplier: latch, start pulse, wait with timeout, writeback.
// Optional MUL_ISSUE_CTRL_STATS_EN adds completed-writeback and busy-cycle counters.
module mul_issue_ctrl #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dec_mul_start,
  input  logic [REG_W-1:0]  dec_rd,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic              flush,
  output logic              mul_go,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic              mul_done,
  input  logic [DATA_W-1:0] mul_result,
  output logic              stall,
  output logic              wb_valid,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
`ifdef MUL_ISSUE_CTRL_STATS_EN
  output logic [31:0]       stat_mul_done,
  output logic [31:0]       stat_busy_cyc,
`endif
  output logic              err_timeout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [REG_W-1:0]   rd_q;
  logic               wb_pend;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rd_q        <= '0;
      mul_go      <= 1'b0;
      mul_a       <= '0;
      mul_b       <= '0;
      wb_pend     <= 1'b0;
      wb_rd       <= '0;
      wb_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      mul_go  <= 1'b0;
      wb_pend <= 1'b0;
      case (state)
        IDLE: if (dec_mul_start && !flush) begin
          mul_a  <= op_a;
          mul_b  <= op_b;
          rd_q   <= dec_rd;
          mul_go <= 1'b1;
          state  <= ISSUE;
        end
        ISSUE: begin
          cnt   <= '0;
          state <= flush ? IDLE : WAIT;
        end
        WAIT: begin
          if (flush) begin
            state <= IDLE;
          end else if (mul_done) begin
            wb_data <= mul_result;
            wb_rd   <= rd_q;
            wb_pend <= (rd_q != '0);  // r0 is hardwired, never written
            state   <= WB;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // A flush arriving during the writeback cycle must still kill the write.
  assign wb_valid = wb_pend & ~flush;
  assign stall    = rst_n & ((state != IDLE) | dec_mul_start);

`ifdef MUL_ISSUE_CTRL_STATS_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stat_mul_done <= '0;
      stat_busy_cyc <= '0;
    end else begin
      if (wb_valid)      stat_mul_done <= stat_mul_done + 32'd1;
      if (state != IDLE) stat_busy_cyc <= stat_busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Randomized bench for mul_issue_ctrl: per-transaction timelines computed from cycle arithmetic.
module tb_mul_issue_ctrl;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          dec_mul_start;
  logic [RW-1:0] dec_rd;
  logic [DW-1:0] op_a, op_b;
  logic          flush;
  logic          mul_go;
  logic [DW-1:0] mul_a, mul_b;
  logic          mul_done;
  logic [DW-1:0] mul_result;
  logic          stall, wb_valid;
  logic [RW-1:0] wb_rd;
  logic [DW-1:0] wb_data;
  logic          err_timeout;
`ifdef MUL_ISSUE_CTRL_STATS_EN
  logic [31:0]   stat_mul_done, stat_busy_cyc;
`endif

  mul_issue_ctrl #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .dec_mul_start(dec_mul_start), .dec_rd(dec_rd),
    .op_a(op_a), .op_b(op_b), .flush(flush), .mul_go(mul_go), .mul_a(mul_a),
    .mul_b(mul_b), .mul_done(mul_done), .mul_result(mul_result), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`ifdef MUL_ISSUE_CTRL_STATS_EN
    .stat_mul_done(stat_mul_done), .stat_busy_cyc(stat_busy_cyc),
`endif
    .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit err_m = 0;
  int st_done_m = 0;
  int st_busy_m = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_stats();
`ifdef MUL_ISSUE_CTRL_STATS_EN
    chk("stat_mul_done", stat_mul_done, st_done_m);
    chk("stat_busy_cyc", stat_busy_cyc, st_busy_m);
`endif
  endtask

  // One mul seen at cycle 0. k>0: mul_done at cycle k; k==0: never answers.
  // f>=1: flush at cycle f. hold: keep dec_mul_start high while busy.
  task automatic run_tx(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [RW-1:0] rd,
                        input int k, input int f, input bit hold, input int tail);
    bit done = (k > 0);
    int last = done ? k + 1 : TO + 1;
    bit wb_killed = 0;
    bit wrote, timed_out, wbv_exp;
    logic [DW-1:0] prod = a * b;
    if (f >= 1 && f <= last) begin
      if (done && f == k + 1) wb_killed = 1;
      else last = f;
    end
    wrote     = done && (last == k + 1);
    timed_out = !done && (last == TO + 1) && !(f == TO + 1);
    wbv_exp   = wrote && (rd != 0) && !wb_killed;
    for (int t = 0; t <= last + tail; t++) begin
      @(negedge clk);
      if (t == 0)         dec_mul_start = 1'b1;
      else if (t <= last) dec_mul_start = hold ? 1'b1 : 1'($urandom_range(0, 1));
      else                dec_mul_start = 1'b0;
      dec_rd     = (t == 0) ? rd : RW'($urandom);
      op_a       = (t == 0) ? a : $urandom;
      op_b       = (t == 0) ? b : $urandom;
      flush      = (t == f);
      mul_done   = (done && t == k) || (t == 1 && $urandom_range(0, 2) == 0)
                   || (t > last && $urandom_range(0, 1) == 1);
      mul_result = (done && t == k) ? prod : $urandom;
      #1;
      if (t == 0) chk_stats();
      chk("stall", stall, (t <= last) || dec_mul_start);
      chk("mul_go", mul_go, t == 1);
      chk("wb_valid", wb_valid, wbv_exp && t == k + 1);
      if (t >= 1) begin
        chk("mul_a", mul_a, a);
        chk("mul_b", mul_b, b);
      end
      if (wrote && t >= k + 1) begin
        chk("wb_rd", wb_rd, rd);
        chk("wb_data", wb_data, prod);
      end
      chk("err_timeout", err_timeout, err_m || (timed_out && t > last));
    end
    if (timed_out) err_m = 1;
    st_done_m += int'(wbv_exp);
    st_busy_m += last;
  endtask

  task automatic reset_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0; dec_mul_start = 1'b1; flush = 1'b0;
      mul_done = $urandom_range(0, 1); mul_result = $urandom;
      #1;
      chk("stall_in_rst", stall, 1'b0);
      if (i > 0) begin
        chk("rst_mul_go", mul_go, 1'b0);
        chk("rst_wb_valid", wb_valid, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_mul_a", mul_a, '0);
        chk("rst_mul_b", mul_b, '0);
        chk("rst_wb_rd", wb_rd, '0);
        chk("rst_wb_data", wb_data, '0);
      end
    end
    err_m = 0; st_done_m = 0; st_busy_m = 0;
  endtask

  initial begin
    dec_mul_start = 0; dec_rd = 0; op_a = 0; op_b = 0; flush = 0;
    mul_done = 0; mul_result = 0; rst_n = 0;
    reset_cycles(2);
    @(negedge clk);
    rst_n = 1'b1; dec_mul_start = 1'b0; mul_done = 1'b0;
    #1;
    chk("idle_stall", stall, 1'b0);
    chk_stats();

    run_tx(32'd6, 32'd7, 5'd3, 5, -1, 0, 2);   // basic: wb at c6
    run_tx(32'd5, 32'd5, 5'd0, 4, -1, 0, 2);   // r0 destination
    run_tx(32'd9, 32'd3, 5'd7, 6, 3, 0, 3);    // flush in WAIT, late done
    run_tx(32'd2, 32'd8, 5'd4, 3, -1, 0, 1);   // clean issue after flush
    run_tx(32'd11, 32'd13, 5'd9, 0, -1, 0, 2); // timeout
    run_tx(32'd1, 32'd2, 5'd5, 3, 4, 0, 2);    // flush in WB
    run_tx(32'd3, 32'd4, 5'd1, 2, -1, 1, 0);   // back-to-back
    run_tx(32'd7, 32'd8, 5'd2, 4, -1, 1, 2);

    for (int n = 0; n < 40; n++) begin
      int k, f, last;
      logic [RW-1:0] rd;
      k  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, TO + 1));
      last = (k > 0) ? k + 1 : TO + 1;
      f  = -1;
      if ($urandom_range(0, 3) == 0) begin
        if (k == 0)                        f = $urandom_range(1, TO + 1);
        else if ($urandom_range(0, 2) == 0) f = k + 1;
        else                               f = $urandom_range(1, k - 1);
      end
      rd = ($urandom_range(0, 5) == 0) ? '0 : RW'($urandom);
      run_tx($urandom, $urandom, rd, k, f, 1'($urandom_range(0, 1)),
             (last > 0) ? int'($urandom_range(0, 2)) : 0);
    end

    // Reset in the middle of a WAIT
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      dec_mul_start = (t == 0); dec_rd = 5'd6; op_a = 32'd10; op_b = 32'd10;
      flush = 1'b0; mul_done = 1'b0;
    end
    reset_cycles(2);
    @(negedge clk);
    rst_n = 1'b1; dec_mul_start = 1'b0; mul_done = 1'b1; mul_result = 32'd100;
    #1;
    chk("post_rst_stall", stall, 1'b0);
    @(negedge clk);
    mul_done = 1'b0;
    #1;
    chk("post_rst_wb", wb_valid, 1'b0);
    chk("post_rst_go", mul_go, 1'b0);
    chk("post_rst_stall2", stall, 1'b0);
    run_tx(32'd12, 32'd12, 5'd8, 3, -1, 0, 2);
    @(negedge clk);
    #1;
    chk_stats();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
